memory_responder: RTL and testbench

MEMORY_RESPONDER -- requirements
Module: memory_responder

---
 rtl/memory_responder_pkg.sv | 25 ++
 rtl/memory_responder_if.sv | 29 ++
 rtl/sync_ram_1rw.sv | 30 +++
 rtl/memory_responder.sv | 114 +++++++++++
 tb/tb_memory_responder.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/memory_responder_pkg.sv
// Shared types and defaults for the memory responder: FSM states, default widths,
// and the address range check used at request acceptance.
package memory_responder_pkg;

  localparam int DATA_WIDTH_DEF = 16;
  localparam int ADDR_WIDTH_DEF = 9;
  localparam int ADDR_BUS_W     = 16;

  typedef enum logic [2:0] {
    INIT     = 3'd0,
    IDLE     = 3'd1,
    WRITE    = 3'd2,
    READ     = 3'd3,
    READ_OUT = 3'd4,
    ACK_GAP  = 3'd5
  } mem_resp_state_t;

  // True when any address bit at or above the array index width is set.
  function automatic logic addr_out_of_range(input logic [ADDR_BUS_W-1:0] a, input int aw);
    logic [31:0] wide;
    wide = {{(32-ADDR_BUS_W){1'b0}}, a};
    return (wide >> aw) != 32'd0;
  endfunction

endpackage

// File: rtl/memory_responder_if.sv
// Request/acknowledge bundle between a requester (master) and the memory responder (slave).
// Enables are level-held by the requester until the matching one-cycle acknowledge.
interface memory_responder_if
  import memory_responder_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
);

  logic                  wr_enable;
  logic                  rd_enable;
  logic [ADDR_BUS_W-1:0] addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  wr_done;
  logic                  rd_valid;
  logic                  busy;
  logic                  err;

  modport master (
    output wr_enable, rd_enable, addr, wr_data,
    input  rd_data, wr_done, rd_valid, busy, err
  );

  modport slave (
    input  wr_enable, rd_enable, addr, wr_data,
    output rd_data, wr_done, rd_valid, busy, err
  );

endinterface

// File: rtl/sync_ram_1rw.sv
// Single-port RAM, one-cycle synchronous read, write-first; no backpressure.
// Contents are not reset: the owner clears them explicitly.
module sync_ram_1rw
  import memory_responder_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  en_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (en_i) begin
      if (we_i) begin
        mem_q[addr_i] <= wdata_i;
        rdata_o       <= wdata_i;
      end else begin
        rdata_o <= mem_q[addr_i];
      end
    end
  end

endmodule

// File: rtl/memory_responder.sv
// Memory responder: clears the array after reset, then serves held requests with write ack
// at +1 and read data at +2 cycles; busy holds requesters off outside IDLE.
module memory_responder
  import memory_responder_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic              clk,
  input  logic              nRst,
  memory_responder_if.slave bus
);

  mem_resp_state_t       state_q, state_d;
  logic [ADDR_WIDTH-1:0] init_cnt_q, init_cnt_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  oor_q, oor_d;
  logic                  conf_q, conf_d;

  logic                  ram_en;
  logic                  ram_we;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_wdata;
  logic [DATA_WIDTH-1:0] ram_rdata;

  logic                  wr_done;
  logic                  rd_valid;

  sync_ram_1rw #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_ram (
    .clk     (clk),
    .en_i    (ram_en),
    .we_i    (ram_we),
    .addr_i  (ram_addr),
    .wdata_i (ram_wdata),
    .rdata_o (ram_rdata)
  );

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q    <= INIT;
      init_cnt_q <= '0;
      idx_q      <= '0;
      wdata_q    <= '0;
      oor_q      <= 1'b0;
      conf_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      idx_q      <= idx_d;
      wdata_q    <= wdata_d;
      oor_q      <= oor_d;
      conf_q     <= conf_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    idx_d      = idx_q;
    wdata_d    = wdata_q;
    oor_d      = oor_q;
    conf_d     = conf_q;
    ram_en     = 1'b0;
    ram_we     = 1'b0;
    ram_addr   = idx_q;
    ram_wdata  = wdata_q;

    case (state_q)
      INIT: begin
        ram_en     = 1'b1;
        ram_we     = 1'b1;
        ram_addr   = init_cnt_q;
        ram_wdata  = '0;
        init_cnt_d = init_cnt_q + ADDR_WIDTH'(1);
        if (&init_cnt_q) state_d = IDLE;
      end
      IDLE: begin
        if (bus.wr_enable || bus.rd_enable) begin
          idx_d   = bus.addr[ADDR_WIDTH-1:0];
          wdata_d = bus.wr_data;
          oor_d   = addr_out_of_range(bus.addr, ADDR_WIDTH);
          conf_d  = bus.wr_enable && bus.rd_enable;
          // A simultaneous read is dropped; the write proceeds and err flags it.
          state_d = bus.wr_enable ? WRITE : READ;
        end
      end
      WRITE: begin
        ram_en  = !oor_q;
        ram_we  = 1'b1;
        state_d = ACK_GAP;
      end
      READ: begin
        ram_en  = !oor_q;
        state_d = READ_OUT;
      end
      READ_OUT: state_d = ACK_GAP;
      ACK_GAP:  state_d = IDLE;
      default:  state_d = INIT;
    endcase
  end

  assign wr_done      = (state_q == WRITE);
  assign rd_valid     = (state_q == READ_OUT);
  assign bus.wr_done  = wr_done;
  assign bus.rd_valid = rd_valid;
  assign bus.busy     = (state_q != IDLE);
  assign bus.err      = (wr_done || rd_valid) && (oor_q || conf_q);
  assign bus.rd_data  = (rd_valid && !oor_q) ? ram_rdata : '0;

endmodule

// File: tb/tb_memory_responder.sv
// Randomized scoreboard bench for memory_responder against a flat-array reference model.
module tb_memory_responder;

  localparam int AW    = 9;
  localparam int DW    = 16;
  localparam int DEPTH = 512;

  typedef struct {
    bit            is_wr;
    logic [DW-1:0] data;
    bit            err;
    int            cyc;
  } exp_t;

  logic clk = 1'b0;
  logic nRst = 1'b0;
  always #5 clk = ~clk;

  memory_responder_if #(.DATA_WIDTH(DW)) bus ();

  memory_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk  (clk),
    .nRst (nRst),
    .bus  (bus.slave)
  );

  exp_t          exp_q[$];
  exp_t          mon_e;
  logic [DW-1:0] model_mem [DEPTH];
  int            cyc = 0;
  int            n_checks = 0;
  int            n_errors = 0;
  bit            prev_wr = 1'b0;
  bit            prev_rd = 1'b0;
  bit            prev_err = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
  endtask

  // Monitor: pops the scoreboard on every acknowledge and watches pulse widths.
  always @(negedge clk) begin
    if (bus.wr_done || bus.rd_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_ack", 32'(1), 32'(0));
      end else begin
        mon_e = exp_q.pop_front();
        check("ack_wr_done", 32'(bus.wr_done), 32'(mon_e.is_wr));
        check("ack_rd_valid", 32'(bus.rd_valid), 32'(!mon_e.is_wr));
        check("ack_err", 32'(bus.err), 32'(mon_e.err));
        check("ack_cycle", 32'(cyc), 32'(mon_e.cyc));
        if (!mon_e.is_wr) check("rd_data", 32'(bus.rd_data), 32'(mon_e.data));
      end
    end else begin
      check("rd_data_idle_zero", 32'(bus.rd_data), 32'(0));
      if (bus.err) check("err_without_ack", 32'(1), 32'(0));
    end
    if (bus.wr_done) check("wr_done_width", 32'(prev_wr), 32'(0));
    if (bus.rd_valid) check("rd_valid_width", 32'(prev_rd), 32'(0));
    if (bus.err) check("err_width", 32'(prev_err), 32'(0));
    prev_wr  <= bus.wr_done;
    prev_rd  <= bus.rd_valid;
    prev_err <= bus.err;
  end

  // Requester: holds the enables until acknowledged, then drops them for one cycle edge.
  task automatic do_req(input bit wr, input bit rd, input logic [15:0] a, input logic [15:0] d,
                        output int waited, output int ack_cyc);
    exp_t e;
    bit   acc = 1'b0;
    bit   got = 1'b0;
    bus.wr_enable = wr;
    bus.rd_enable = rd;
    bus.addr      = a;
    bus.wr_data   = d;
    waited  = 0;
    ack_cyc = -1;
    for (int i = 0; i < 2000 && !acc; i++) begin
      @(negedge clk);
      if (!bus.busy) acc = 1'b1;
      else waited++;
    end
    if (!acc) begin
      check("accept_timeout", 32'(0), 32'(1));
    end else begin
      e.is_wr = wr;
      e.cyc   = cyc + (wr ? 1 : 2);
      e.err   = (a >= 16'(DEPTH)) || (wr && rd);
      e.data  = '0;
      if (wr) begin
        if (a < 16'(DEPTH)) model_mem[a[AW-1:0]] = d;
      end else begin
        e.data = (a < 16'(DEPTH)) ? model_mem[a[AW-1:0]] : '0;
      end
      exp_q.push_back(e);
      for (int i = 0; i < 10 && !got; i++) begin
        @(negedge clk);
        if (bus.wr_done || bus.rd_valid) begin
          got     = 1'b1;
          ack_cyc = cyc;
        end
      end
      if (!got) begin
        check("ack_timeout", 32'(0), 32'(1));
        void'(exp_q.pop_back());
      end
    end
    @(posedge clk);
    #1;
    bus.wr_enable = 1'b0;
    bus.rd_enable = 1'b0;
  endtask

  initial begin
    int            w;
    int            a1;
    int            a2;
    int            kind;
    logic [15:0]   ra;
    logic [15:0]   rd;
    bit            acc;

    bus.wr_enable = 1'b0;
    bus.rd_enable = 1'b0;
    bus.addr      = '0;
    bus.wr_data   = '0;
    model_clear();

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_busy", 32'(bus.busy), 32'(1));
    check("reset_wr_done", 32'(bus.wr_done), 32'(0));
    check("reset_rd_valid", 32'(bus.rd_valid), 32'(0));
    check("reset_err", 32'(bus.err), 32'(0));
    check("reset_rd_data", 32'(bus.rd_data), 32'(0));

    // Read held from reset release: served only once the array clear is done.
    @(posedge clk);
    #1;
    nRst = 1'b1;
    do_req(1'b0, 1'b1, 16'h01FF, 16'h0000, w, a1);
    check("init_busy_cycles", 32'(w), 32'(512));

    do_req(1'b1, 1'b0, 16'h0080, 16'hA5A5, w, a1);
    do_req(1'b0, 1'b1, 16'h0080, 16'h0000, w, a1);

    do_req(1'b1, 1'b1, 16'h0010, 16'h1234, w, a1);
    do_req(1'b0, 1'b1, 16'h0010, 16'h0000, w, a1);

    do_req(1'b1, 1'b0, 16'h0200, 16'hFFFF, w, a1);
    do_req(1'b0, 1'b1, 16'h0000, 16'h0000, w, a1);

    do_req(1'b0, 1'b1, 16'h0001, 16'h0000, w, a1);
    do_req(1'b0, 1'b1, 16'h0002, 16'h0000, w, a2);
    check("read_ack_spacing", 32'(a2 - a1), 32'(4));

    do_req(1'b1, 1'b0, 16'h0003, 16'h1111, w, a1);
    do_req(1'b1, 1'b0, 16'h0004, 16'h2222, w, a2);
    check("write_ack_spacing", 32'(a2 - a1), 32'(3));

    for (int n = 0; n < 80; n++) begin
      kind = int'($urandom_range(0, 7));
      ra   = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 15));
      rd   = 16'($urandom);
      do_req(kind <= 3, kind == 0 || kind >= 4, ra, rd, w, a1);
    end

    // Reset while a read is in its array-access cycle.
    do_req(1'b1, 1'b0, 16'h0080, 16'hBEEF, w, a1);
    bus.rd_enable = 1'b1;
    bus.addr      = 16'h0080;
    acc = 1'b0;
    for (int i = 0; i < 10 && !acc; i++) begin
      @(negedge clk);
      if (!bus.busy) acc = 1'b1;
    end
    check("abort_read_accepted", 32'(acc), 32'(1));
    @(posedge clk);
    #2;
    nRst = 1'b0;
    model_clear();
    @(negedge clk);
    check("abort_busy", 32'(bus.busy), 32'(1));
    check("abort_rd_valid", 32'(bus.rd_valid), 32'(0));
    bus.rd_enable = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    nRst = 1'b1;
    do_req(1'b0, 1'b1, 16'h0080, 16'h0000, w, a1);
    check("reinit_busy_cycles", 32'(w), 32'(512));

    repeat (4) @(posedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
